// File: rtl/div_pkg.sv
// div_pkg -- shared types and defaults for the sequential integer divider.
//
// Contents:
//   XLEN_DEFAULT : default operand/result width
//   div_op_e     : operation select, encoded as RV32M funct3[1:0]
//   div_state_e  : divider control states
package div_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// div_step -- one combinational restoring-division step.
//
// The partial remainder and the quotient register form one double-width
// shift register {rem, quo}.  Each step shifts it left by one, trial-subtracts
// the divisor from the upper half, and keeps the difference (quotient bit 1)
// when it does not go negative, otherwise keeps the shifted value (bit 0).
//
// Ports:
//   rem_i     in  XLEN  partial remainder (always < divisor, or the running
//                       dividend prefix when the divisor is zero)
//   quo_i     in  XLEN  quotient / remaining dividend bits
//   divisor_i in  XLEN  unsigned divisor magnitude
//   rem_o     out XLEN  next partial remainder
//   quo_o     out XLEN  next quotient register
module div_step
  import div_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0]   shifted;
  logic            fits;
  logic [XLEN-1:0] diff;

  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    // The trial subtraction is done on XLEN+1 bits: shifted can exceed the
    // XLEN range, but whenever it fits the difference is below the divisor,
    // so the low XLEN bits of the modular difference are exact.
    fits    = (shifted >= {1'b0, divisor_i});
    diff    = shifted[XLEN-1:0] - divisor_i;
    rem_o   = fits ? diff : shifted[XLEN-1:0];
    quo_o   = {quo_i[XLEN-2:0], fits};
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider -- iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
//
// One quotient bit is produced per clock; a result takes XLEN+1 edges after
// the accepting edge, independent of operands.  Signed operations run on
// operand magnitudes and the sign is restored when the result is registered.
// Divide-by-zero and signed overflow are flagged when the operation is
// accepted and substituted at finalize time.
//
// Ports:
//   i_clk       in  1     clock, rising edge
//   i_rst       in  1     synchronous active-high reset
//   i_start     in  1     request strobe, sampled only while idle
//   i_op        in  2     00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_dividend  in  XLEN  rs1
//   i_divisor   in  XLEN  rs2
//   i_kill      in  1     abort the operation in flight / block acceptance
//   o_busy      out 1     operation in progress (BUSY or DONE)
//   o_valid     out 1     one-cycle result strobe
//   o_result    out XLEN  quotient or remainder, held until next result
module seq_divider
  import div_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  input  logic            i_kill,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam int CNT_W = (XLEN > 2) ? $clog2(XLEN) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

  // Unsigned magnitude of a two's-complement value.  The most negative value
  // maps to 2^(XLEN-1), which is representable as an unsigned XLEN number.
  function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] v,
                                                input logic                   neg);
    logic signed [XLEN-1:0] n;
    n = -v;
    return neg ? $unsigned(n) : $unsigned(v);
  endfunction

  function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] m,
                                                 input logic            neg);
    logic signed [XLEN-1:0] s;
    s = -$signed(m);
    return neg ? $unsigned(s) : m;
  endfunction

  // Result selection at finalize: special cases override the iterated value.
  function automatic logic [XLEN-1:0] finalize(input div_op_e         op,
                                               input logic [XLEN-1:0] quo,
                                               input logic [XLEN-1:0] rem,
                                               input logic [XLEN-1:0] dividend,
                                               input logic            quo_neg,
                                               input logic            rem_neg,
                                               input logic            div0,
                                               input logic            ovf);
    logic [XLEN-1:0] res;
    if (op == DIV || op == DIVU) begin
      if (div0)     res = '1;
      else if (ovf) res = MIN_NEG;
      else          res = apply_sign(quo, quo_neg);
    end else begin
      if (div0)     res = dividend;
      else if (ovf) res = '0;
      else          res = apply_sign(rem, rem_neg);
    end
    return res;
  endfunction

  div_state_e      state_q;
  div_op_e         op_q;
  logic            qneg_q, rneg_q, div0_q, ovf_q;
  logic [XLEN-1:0] dvd_q, dsr_q, rem_q, quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] result_q;
  logic            valid_q;

  // Acceptance-time decode of the incoming request.
  logic            signed_op_d, a_neg_d, b_neg_d;
  logic            div0_d, ovf_d;
  logic [XLEN-1:0] a_mag_d, b_mag_d;
  logic [XLEN-1:0] rem_d, quo_d;

  always_comb begin
    signed_op_d = ~i_op[0];
    a_neg_d     = signed_op_d & i_dividend[XLEN-1];
    b_neg_d     = signed_op_d & i_divisor[XLEN-1];
    a_mag_d     = magnitude($signed(i_dividend), a_neg_d);
    b_mag_d     = magnitude($signed(i_divisor), b_neg_d);
    div0_d      = (i_divisor == '0);
    ovf_d       = signed_op_d & (i_dividend == MIN_NEG) & (i_divisor == '1);
  end

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dsr_q),
    .rem_o     (rem_d),
    .quo_o     (quo_d)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      op_q     <= DIV;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        // Accept: latch op, signs, magnitudes and special-case flags.
        IDLE: begin
          if (i_start && !i_kill) begin
            op_q    <= div_op_e'(i_op);
            qneg_q  <= a_neg_d ^ b_neg_d;
            rneg_q  <= a_neg_d;
            div0_q  <= div0_d;
            ovf_q   <= ovf_d;
            dvd_q   <= i_dividend;
            dsr_q   <= b_mag_d;
            quo_q   <= a_mag_d;
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        // Iterate: one restoring step per edge, XLEN steps in total.
        BUSY: begin
          if (i_kill) begin
            state_q <= IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) state_q <= DONE;
          end
        end
        // Finalize: sign correction, special-case select, result strobe.
        DONE: begin
          if (!i_kill) begin
            result_q <= finalize(op_q, quo_q, rem_q, dvd_q, qneg_q, rneg_q,
                                 div0_q, ovf_q);
            valid_q  <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy   = (state_q != IDLE);
  assign o_valid  = valid_q;
  assign o_result = result_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 1;

  logic            clk = 1'b0;
  logic            i_rst, i_start, i_kill;
  logic [1:0]      i_op;
  logic [XLEN-1:0] i_dividend, i_divisor;
  logic            o_busy, o_valid;
  logic [XLEN-1:0] o_result;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t_start = 0;
  logic [XLEN-1:0] exp_q[$];

  seq_divider #(.XLEN(XLEN)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_op       (i_op),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .i_kill     (i_kill),
    .o_busy     (o_busy),
    .o_valid    (o_valid),
    .o_result   (o_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Independent reference: RISC-V M semantics via SV operators.
  function automatic logic [XLEN-1:0] ref_model(input logic [1:0] op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa, sb;
    sa = a; sb = b;
    if (b == 0) return (op[1] == 1'b0) ? '1 : a;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return (op[1] == 1'b0) ? 32'h8000_0000 : 32'h0;
    case (op)
      2'b00:   return $unsigned(sa / sb);
      2'b01:   return a / b;
      2'b10:   return $unsigned(sa % sb);
      default: return a % b;
    endcase
  endfunction

  // Drive one request; the accepting edge is the next posedge.
  task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] expv);
    @(negedge clk);
    i_start = 1'b1; i_op = op; i_dividend = a; i_divisor = b;
    t_start = cyc;
    exp_q.push_back(expv);
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_valid(output bit got);
    int k = 0;
    while (!o_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    got = o_valid;
  endtask

  task automatic count_valid(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (o_valid) seen++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    i_rst = 1'b1;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_result !== '0) begin
      failures++;
      $display("FAIL reset_state busy=%b valid=%b result=%h required 0/0/0",
               o_busy, o_valid, o_result);
    end
  endtask

  task automatic test_basic();
    logic [1:0]      ops[8] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b11};
    logic [XLEN-1:0] as[8]  = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                32'd7, 32'd7, 32'hFFFF_FF9C, 32'hFFFF_FFFF};
    logic [XLEN-1:0] bs[8]  = '{32'd7, 32'd7, 32'd2, 32'd2,
                                32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFF6, 32'h10};
    logic [XLEN-1:0] ex[8]  = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                32'hFFFF_FFFD, 32'd1, 32'd10, 32'hF};
    bit got;
    logic [XLEN-1:0] e;
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], as[i], bs[i], ex[i]);
      checks++;
      if (o_busy !== 1'b1) begin
        failures++;
        $display("FAIL basic_busy[%0d] busy=%b required 1", i, o_busy);
      end
      wait_valid(got);
      e = exp_q.pop_front();
      checks++;
      if (!got) begin
        failures++;
        $display("FAIL basic_timeout[%0d] no o_valid", i);
        continue;
      end
      if (o_result !== e) begin
        failures++;
        $display("FAIL basic_result[%0d] got=%h required=%h", i, o_result, e);
      end
      checks++;
      if (cyc - t_start - 1 != LAT) begin
        failures++;
        $display("FAIL basic_latency[%0d] got=%0d required=%0d", i, cyc - t_start - 1, LAT);
      end
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b0 || o_result !== e || o_busy !== 1'b0) begin
        failures++;
        $display("FAIL basic_hold[%0d] valid=%b busy=%b result=%h required 0/0/%h",
                 i, o_valid, o_busy, o_result, e);
      end
    end
  endtask

  task automatic test_special();
    logic [1:0]      ops[5] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b10};
    logic [XLEN-1:0] as[5]  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB};
    logic [XLEN-1:0] bs[5]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    logic [XLEN-1:0] ex[5]  = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFB};
    bit got;
    logic [XLEN-1:0] e;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], as[i], bs[i], ex[i]);
      wait_valid(got);
      e = exp_q.pop_front();
      checks++;
      if (!got) begin
        failures++;
        $display("FAIL special_timeout[%0d] no o_valid", i);
        continue;
      end
      if (o_result !== e) begin
        failures++;
        $display("FAIL special_result[%0d] got=%h required=%h", i, o_result, e);
      end
      checks++;
      if (cyc - t_start - 1 != LAT) begin
        failures++;
        $display("FAIL special_latency[%0d] got=%0d required=%0d", i, cyc - t_start - 1, LAT);
      end
    end
  endtask

  task automatic test_random();
    bit got;
    logic [1:0] op;
    logic [XLEN-1:0] a, b, e;
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i % 2 == 0) ? XLEN'($urandom_range(1, 300)) : $urandom;
      if (i == 3) a = 32'h8000_0000;
      if (i == 5) b = 32'h8000_0000;
      issue(op, a, b, ref_model(op, a, b));
      wait_valid(got);
      e = exp_q.pop_front();
      checks++;
      if (!got) begin
        failures++;
        $display("FAIL random_timeout[%0d] no o_valid", i);
      end else if (o_result !== e) begin
        failures++;
        $display("FAIL random_result[%0d] op=%0d a=%h b=%h got=%h required=%h",
                 i, op, a, b, o_result, e);
      end
    end
  endtask

  task automatic test_ignore_and_kill();
    bit got;
    int seen;
    logic [XLEN-1:0] e;
    // start pulsed mid-operation must not disturb the first request
    issue(2'b01, 32'd1000, 32'd3, 32'd333);
    repeat (4) @(negedge clk);
    i_start = 1'b1; i_op = 2'b11; i_dividend = 32'd77; i_divisor = 32'd5;
    @(negedge clk);
    i_start = 1'b0;
    wait_valid(got);
    e = exp_q.pop_front();
    checks++;
    if (!got || o_result !== e || cyc - t_start - 1 != LAT) begin
      failures++;
      $display("FAIL ignore_start got=%b result=%h lat=%0d required 1/%h/%0d",
               got, o_result, cyc - t_start - 1, e, LAT);
    end
    // kill at E10
    issue(2'b00, 32'd50, 32'd6, 32'd8);
    repeat (9) @(negedge clk);
    i_kill = 1'b1;
    @(negedge clk);
    i_kill = 1'b0;
    void'(exp_q.pop_front());
    checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL kill_idle busy=%b valid=%b required 0/0", o_busy, o_valid);
    end
    count_valid(40, seen);
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL kill_no_valid strobes=%0d required 0", seen);
    end
    // kill in IDLE blocks a simultaneous start
    @(negedge clk);
    i_start = 1'b1; i_kill = 1'b1; i_op = 2'b01; i_dividend = 32'd9; i_divisor = 32'd2;
    @(negedge clk);
    i_start = 1'b0; i_kill = 1'b0;
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL kill_blocks_start busy=%b required 0", o_busy);
    end
    // next request accepted normally
    issue(2'b10, 32'd50, 32'd6, 32'd2);
    wait_valid(got);
    e = exp_q.pop_front();
    checks++;
    if (!got || o_result !== e) begin
      failures++;
      $display("FAIL after_kill got=%b result=%h required 1/%h", got, o_result, e);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    issue(2'b01, 32'd999, 32'd10, 32'd99);
    repeat (19) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    void'(exp_q.pop_front());
    checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_result !== '0) begin
      failures++;
      $display("FAIL reset_mid busy=%b valid=%b result=%h required 0/0/0",
               o_busy, o_valid, o_result);
    end
    count_valid(40, seen);
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_mid_no_valid strobes=%0d required 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    bit got;
    int t1;
    logic [XLEN-1:0] e;
    issue(2'b01, 32'd100, 32'd7, 32'd14);
    wait_valid(got);
    e = exp_q.pop_front();
    t1 = cyc;
    checks++;
    if (!got || o_result !== e) begin
      failures++;
      $display("FAIL b2b_first got=%b result=%h required 1/%h", got, o_result, e);
    end
    // start while o_valid is high
    i_start = 1'b1; i_op = 2'b11; i_dividend = 32'd100; i_divisor = 32'd7;
    exp_q.push_back(32'd2);
    @(negedge clk);
    i_start = 1'b0;
    wait_valid(got);
    e = exp_q.pop_front();
    checks++;
    if (!got || o_result !== e) begin
      failures++;
      $display("FAIL b2b_second got=%b result=%h required 1/%h", got, o_result, e);
    end
    checks++;
    if (cyc - t1 != XLEN + 2) begin
      failures++;
      $display("FAIL b2b_gap got=%0d required=%0d", cyc - t1, XLEN + 2);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_kill = 1'b0; i_op = 2'b00;
    i_dividend = '0; i_divisor = '0;
    test_reset();
    test_basic();
    test_special();
    test_random();
    test_ignore_and_kill();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
